gate_truth_capture: RTL and testbench
=====================================

# gate_truth_capture

Sequential truth-table exerciser for the two-input gate bank (invert, and2, or2, xor2, nand2). It drives the shared gate inputs through all four input vectors, waits a programmable settle time, and captures the five gate outputs into a 20-bit truth-table register. It compares the captured values against the ideal gate functions and reports a pass flag and a per-gate fail mask. It sits directly upstream of the gate bank, driving it, and directly downstream of it, consuming its outputs.

## Interface
- SETTLE, default 1: wait cycles after each new vector is driven, before the outputs are sampled. Legal range is 1..15.

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a sweep; sampled only in IDLE
- i0_drv  out  1  registered drive to gate input i0 (inverter input i is also tied to i0)
- i1_drv  out  1  registered drive to gate input i1
- o1..o5  in  1 each  gate outputs: o1 invert, o2 and2, o3 or2, o4 xor2, o5 nand2
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- pass  out  1  last sweep matched on all gates; held until the next start
- fail_mask  out  5  bit j set means o(j+1) mismatched on at least one vector
- table  out  20  captured outputs; table[5k+4:5k] = {o5,o4,o3,o2,o1} for vector k

## Operation
- Vector index k is 2 bits; i1_drv = k[1], i0_drv = k[0].
- Expected outputs per vector:
  - o1 = ~i0
  - o2 = i0&i1
  - o3 = i0|i1
  - o4 = i0^i1
  - o5 = ~(i0&i1)
- FSM states are IDLE, WAIT, SAMPLE and DONE.
- IDLE:
  - start=1 clears table and fail_mask, clears pass, and sets k=0, drives 00, clears the wait counter, then moves to WAIT.
  - start=0 keeps the block in IDLE.
- WAIT:
  - The wait counter increments each cycle.
  - When the counter reaches SETTLE-1, the FSM moves to SAMPLE.
- SAMPLE (one cycle): on the closing edge the block
  - writes {o5..o1} into slice k of table;
  - ORs the per-bit mismatch into fail_mask;
  - if k==3, moves to DONE;
  - otherwise increments k, updates the drives, clears the counter and returns to WAIT.
- DONE (one cycle):
  - done=1 and pass=(fail_mask==0).
  - Next state is IDLE.
- start is ignored in WAIT, SAMPLE and DONE. There is no queuing; a start held high through DONE launches a new sweep on the first IDLE cycle.
- Gate outputs are treated as combinational. No synchronisation is applied to o1..o5.

## Timing
- Reset values: i0_drv=0, i1_drv=0, busy=0, done=0, pass=0, fail_mask=0, table=0, state IDLE, k=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial result is retained.
- busy=1 exactly in WAIT and SAMPLE.
- The drives change only on the edge that enters WAIT. They are stable for SETTLE+1 cycles before the sample edge.
- Take edge E0 as the edge at which start is accepted:
  - Vector k is sampled at edge E0 + (k+1)(SETTLE+1).
  - The DONE state is entered at edge E0 + 4(SETTLE+1), and done is high for the following cycle.
  - With SETTLE=1, done is high after edge E0+8.
- fail_mask and table update only at SAMPLE edges. pass updates only on entering DONE.
- Outputs are stable between updates.
- The drives hold their last value (11) after the sweep until the next start.

## Test plan
- Correct gate bank, SETTLE=1, start pulsed once:
  - Required: table=20'h37791, fail_mask=0, pass=1.
  - Required: done high for exactly one cycle, 8 cycles after the start edge.
  - Required: busy high for 8 cycles.
- o2 stuck at 0, otherwise correct:
  - Required: table[19:15]=5'b00100 and fail_mask=5'b00010.
  - Required: pass=0.
- o4 stuck at 1:
  - Required: mismatches at k=0 and k=3, giving fail_mask=5'b01000.
  - Required: pass=0.
- SETTLE=3 with a correct bank:
  - Required: drive changes 4 cycles apart.
  - Required: done 16 cycles after the start edge.
  - Required: table=20'h37791.
- start re-pulsed during WAIT, and held high through DONE:
  - Required: the mid-sweep pulse is ignored.
  - Required: a new sweep begins on the first IDLE cycle, with fail_mask and table cleared.
- rst_n dropped during k=2 WAIT:
  - Required: all outputs return to zero asynchronously.
  - Required: the next start runs a full, clean sweep with pass=1.

Source files
------------

// File: rtl/gate_truth_capture.sv
// Sweeps the two-input gate bank through all four input vectors, captures the
// five gate outputs per vector and checks them against the ideal gate functions.
module gate_truth_capture #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        i0_drv,
    output logic        i1_drv,
    input  logic        o1,
    input  logic        o2,
    input  logic        o3,
    input  logic        o4,
    input  logic        o5,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_mask,
    output logic [19:0] truth_table
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] k;
    logic [3:0] cnt;
    logic [4:0] observed;
    logic [4:0] ideal;
    logic [4:0] mismatch;

    // The vector index register is the drive itself, so drives only move with k.
    assign i0_drv = k[0];
    assign i1_drv = k[1];

    assign observed = {o5, o4, o3, o2, o1};
    assign ideal    = {~(k[0] & k[1]), k[0] ^ k[1], k[0] | k[1], k[0] & k[1], ~k[0]};
    assign mismatch = observed ^ ideal;

    assign busy = (state == WAIT) || (state == SAMPLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WAIT;
            WAIT:    if (cnt == LAST_WAIT) state_next = SAMPLE;
            SAMPLE:  state_next = (k == 2'd3) ? DONE : WAIT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gate outputs are taken straight off the bank on the closing edge of SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k           <= 2'd0;
            cnt         <= 4'd0;
            pass        <= 1'b0;
            fail_mask   <= 5'd0;
            truth_table <= 20'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k           <= 2'd0;
                        cnt         <= 4'd0;
                        pass        <= 1'b0;
                        fail_mask   <= 5'd0;
                        truth_table <= 20'd0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                end
                SAMPLE: begin
                    truth_table[5*k +: 5] <= observed;
                    fail_mask             <= fail_mask | mismatch;
                    if (k == 2'd3) begin
                        pass <= ((fail_mask | mismatch) == 5'd0);
                    end else begin
                        k   <= k + 2'd1;
                        cnt <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_capture.sv
// Drives two capture blocks (SETTLE=1 and SETTLE=3) against a faultable gate bank
// and checks every output each cycle against a sweep-timeline model.
module tb_gate_truth_capture;

    logic clk = 1'b0;
    logic rst_n;

    logic        start    [2];
    logic        i0_drv   [2];
    logic        i1_drv   [2];
    logic        busy     [2];
    logic        done     [2];
    logic        pass     [2];
    logic [4:0]  fail_mask[2];
    logic [19:0] ttab     [2];
    logic [4:0]  obus     [2];
    logic [4:0]  s0       [2];
    logic [4:0]  s1       [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Ideal bank response as {o5,o4,o3,o2,o1} for inputs (i1,i0).
    function automatic logic [4:0] ideal(input logic a1, input logic a0);
        return {~(a0 & a1), a0 ^ a1, a0 | a1, a0 & a1, ~a0};
    endfunction

    function automatic int period(input int i);
        return ((i == 0) ? 1 : 3) + 1;
    endfunction

    function automatic logic [4:0] ideal_k(input int k);
        logic [1:0] kb;
        kb = 2'(k);
        return ideal(kb[1], kb[0]);
    endfunction

    function automatic logic [4:0] seen_k(input int i, input int k);
        return (ideal_k(k) & ~s0[i]) | s1[i];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S = (g == 0) ? 1 : 3;
        assign obus[g] = (ideal(i1_drv[g], i0_drv[g]) & ~s0[g]) | s1[g];
        gate_truth_capture #(.SETTLE(S)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .i0_drv     (i0_drv[g]),
            .i1_drv     (i1_drv[g]),
            .o1         (obus[g][0]),
            .o2         (obus[g][1]),
            .o3         (obus[g][2]),
            .o4         (obus[g][3]),
            .o5         (obus[g][4]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .fail_mask  (fail_mask[g]),
            .truth_table(ttab[g])
        );
    end

    // Model: m_t counts edges since the accepting edge; every period-th edge samples a vector.
    int          m_t   [2];
    logic        m_act [2];
    logic        m_done[2];
    logic        m_pass[2];
    logic [1:0]  m_kv  [2];
    logic [4:0]  m_mask[2];
    logic [19:0] m_tab [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] <= 0;  m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_pass[i] <= 1'b0;
                m_kv[i] <= 2'd0; m_mask[i] <= 5'd0; m_tab[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (m_act[i]) begin
                    m_t[i] <= m_t[i] + 1;
                    if ((m_t[i] + 1) % period(i) == 0) begin
                        m_tab[i][5*((m_t[i]+1)/period(i)-1) +: 5] <= seen_k(i, (m_t[i]+1)/period(i)-1);
                        m_mask[i] <= m_mask[i] | (seen_k(i, (m_t[i]+1)/period(i)-1) ^ ideal_k((m_t[i]+1)/period(i)-1));
                        if ((m_t[i]+1)/period(i) == 4) begin
                            m_act[i]  <= 1'b0;
                            m_done[i] <= 1'b1;
                            m_pass[i] <= ((m_mask[i] | (seen_k(i, 3) ^ ideal_k(3))) == 5'd0);
                        end else begin
                            m_kv[i] <= 2'((m_t[i]+1)/period(i));
                        end
                    end
                end else if (start[i]) begin
                    m_act[i] <= 1'b1; m_t[i] <= 0; m_kv[i] <= 2'd0;
                    m_tab[i] <= 20'd0; m_mask[i] <= 5'd0; m_pass[i] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input int i, input logic [19:0] act, input logic [19:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: got %h, want %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic checkReset(input int i, input string tag);
        checkOutput({tag, "_busy"}, i, 20'(busy[i]), 20'd0);
        checkOutput({tag, "_done"}, i, 20'(done[i]), 20'd0);
        checkOutput({tag, "_pass"}, i, 20'(pass[i]), 20'd0);
        checkOutput({tag, "_mask"}, i, 20'(fail_mask[i]), 20'd0);
        checkOutput({tag, "_table"}, i, ttab[i], 20'd0);
        checkOutput({tag, "_drv"}, i, 20'({i1_drv[i], i0_drv[i]}), 20'd0);
    endtask

    // Pulses start on an idle block, then counts cycles to done and busy cycles.
    task automatic applyStimulus(input int i, output int ncyc, output int nbusy);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        ncyc  = 0;
        nbusy = busy[i] ? 1 : 0;
        while (!done[i] && ncyc < 100) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (busy[i]) nbusy++;
        end
        if (!done[i]) checkOutput("done_timeout", i, 20'(done[i]), 20'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int i);
        int n;
        n = 0;
        while (!done[i] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done[i]) checkOutput("wait_done_timeout", i, 20'(done[i]), 20'd1);
    endtask

    initial begin
        int ncyc;
        int nbusy;
        int n;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; s0[i] = 5'd0; s1[i] = 5'd0;
        end
        #1 rst_n = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    for (int i = 0; i < 2; i++) begin
                        checkOutput("busy", i, 20'(busy[i]), 20'(m_act[i]));
                        checkOutput("done", i, 20'(done[i]), 20'(m_done[i]));
                        checkOutput("pass", i, 20'(pass[i]), 20'(m_pass[i]));
                        checkOutput("fail_mask", i, 20'(fail_mask[i]), 20'(m_mask[i]));
                        checkOutput("table", i, ttab[i], m_tab[i]);
                        checkOutput("drive", i, 20'({i1_drv[i], i0_drv[i]}), 20'(m_kv[i]));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        checkReset(0, "reset");
        checkReset(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Correct bank, SETTLE=1
        applyStimulus(0, ncyc, nbusy);
        checkOutput("s1_done_latency", 0, 20'(ncyc), 20'd8);
        checkOutput("s1_busy_cycles", 0, 20'(nbusy), 20'd8);
        checkOutput("s1_table", 0, ttab[0], 20'h37791);
        checkOutput("s1_mask", 0, 20'(fail_mask[0]), 20'd0);
        checkOutput("s1_pass", 0, 20'(pass[0]), 20'd1);
        checkOutput("s1_drive_hold", 0, 20'({i1_drv[0], i0_drv[0]}), 20'd3);

        // o2 stuck at 0
        s0[0] = 5'b00010;
        applyStimulus(0, ncyc, nbusy);
        checkOutput("o2s0_slice3", 0, 20'(ttab[0][19:15]), 20'b00100);
        checkOutput("o2s0_mask", 0, 20'(fail_mask[0]), 20'b00010);
        checkOutput("o2s0_pass", 0, 20'(pass[0]), 20'd0);
        s0[0] = 5'd0;

        // o4 stuck at 1
        s1[0] = 5'b01000;
        applyStimulus(0, ncyc, nbusy);
        checkOutput("o4s1_mask", 0, 20'(fail_mask[0]), 20'b01000);
        checkOutput("o4s1_pass", 0, 20'(pass[0]), 20'd0);

        // Correct bank, SETTLE=3
        applyStimulus(1, ncyc, nbusy);
        checkOutput("s3_done_latency", 1, 20'(ncyc), 20'd16);
        checkOutput("s3_busy_cycles", 1, 20'(nbusy), 20'd16);
        checkOutput("s3_table", 1, ttab[1], 20'h37791);
        checkOutput("s3_pass", 1, 20'(pass[1]), 20'd1);

        // Re-pulse during WAIT, then hold start through DONE (o4 still stuck)
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        checkOutput("repulse_drive", 0, 20'({i1_drv[0], i0_drv[0]}), 20'd1);
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b1;
        waitDone(0);
        checkOutput("held_first_mask", 0, 20'(fail_mask[0]), 20'b01000);
        s1[0] = 5'd0;
        @(posedge clk);
        #1;
        checkOutput("held_idle_busy", 0, 20'(busy[0]), 20'd0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        checkOutput("held_restart_busy", 0, 20'(busy[0]), 20'd1);
        checkOutput("held_restart_mask", 0, 20'(fail_mask[0]), 20'd0);
        checkOutput("held_restart_table", 0, ttab[0], 20'd0);
        waitDone(0);
        checkOutput("held_second_pass", 0, 20'(pass[0]), 20'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset during the k=2 WAIT
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n = 0;
        while (!(busy[0] && i1_drv[0] && !i0_drv[0]) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("k2_reached", 0, 20'({i1_drv[0], i0_drv[0]}), 20'd2);
        #2 rst_n = 1'b0;
        #1;
        checkReset(0, "abort");
        #3 rst_n = 1'b1;
        applyStimulus(0, ncyc, nbusy);
        checkOutput("post_abort_table", 0, ttab[0], 20'h37791);
        checkOutput("post_abort_pass", 0, 20'(pass[0]), 20'd1);

        // Random starts and faults on both blocks
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    s0[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
                    s1[i] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; s0[i] = 5'd0; s1[i] = 5'd0;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
